// File: rtl/btn_pkg.sv
// Shared types and default timing for the multi-channel button conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

  // Auto-repeat FSM encoding
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_DLY = 2'd1,
    HOLD_REP = 2'd2
  } rep_state_e;

  // Default timing for a 50 MHz core clock
  localparam int unsigned CLK_HZ           = 50_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = CLK_HZ / 100;  // 10 ms
  localparam int unsigned DEF_REPEAT_DLY   = CLK_HZ;        // 1 s
  localparam int unsigned DEF_REPEAT_PER   = CLK_HZ / 5;    // 200 ms

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop sync, stability debouncer, press edge, auto-repeat FSM.
// Latency: level/press 2+DEBOUNCE_CYC cycles after a clean raw edge; repeat pulses registered.
// Backpressure: none; level, press and rep are free-running one-cycle/level outputs.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic rep_en,
  output logic level,
  output logic press,
  output logic rep
);

  localparam int unsigned      DB_LAST  = DEBOUNCE_CYC - 1;
  localparam int unsigned      DLY_LAST = REPEAT_DLY - 1;
  localparam int unsigned      PER_LAST = REPEAT_PER - 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] tmr;
  rep_state_e       state;
  logic             accept;
  logic             rise;
  logic             fall;

  // Level change is taken on the DEBOUNCE_CYC-th consecutive differing sample
  assign accept = (sync2 != level) && (32'(db_cnt) >= DB_LAST);
  assign rise   = accept & sync2;
  assign fall   = accept & ~sync2;

  // Two-flop synchroniser for the asynchronous raw input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Stability counter; press pulse coincides with the first cycle of the new high level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= rise;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        level  <= sync2;
        db_cnt <= '0;
      end else if (db_cnt != CNT_MAX) begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
    end
  end

  // Auto-repeat: initial hold delay, then periodic repeats; drops out on release or disable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tmr   <= '0;
      rep   <= 1'b0;
    end else begin
      rep <= 1'b0;
      if (!rep_en || fall) begin
        state <= IDLE;
        tmr   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state <= HOLD_DLY;
              tmr   <= '0;
            end
          end
          HOLD_DLY: begin
            if (32'(tmr) >= DLY_LAST) begin
              rep   <= 1'b1;
              state <= HOLD_REP;
              tmr   <= '0;
            end else if (tmr != CNT_MAX) begin
              tmr <= tmr + CNT_W'(1);
            end
          end
          HOLD_REP: begin
            if (32'(tmr) >= PER_LAST) begin
              rep <= 1'b1;
              tmr <= '0;
            end else if (tmr != CNT_MAX) begin
              tmr <= tmr + CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/button_conditioner_multi.sv
// N-channel button conditioner: per-channel debounce/repeat plus a pending-bit event queue.
// Latency: event presented 2 cycles after the press/repeat pulse; one idle cycle between events.
// Backpressure: evt_valid/evt_idx/evt_repeat held until evt_ready; events colliding on a pending channel set sticky evt_overrun.
module button_conditioner_multi
  import btn_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_EN    = 1,
  parameter int unsigned REPEAT_DLY   = DEF_REPEAT_DLY,
  parameter int unsigned REPEAT_PER   = DEF_REPEAT_PER,
  parameter int unsigned IDX_W        = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_raw,
  input  logic [NUM_CH-1:0] repeat_mask,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_press,
  output logic              evt_valid,
  output logic [IDX_W-1:0]  evt_idx,
  output logic              evt_repeat,
  input  logic              evt_ready,
  output logic              evt_overrun
);

  logic [NUM_CH-1:0] rep_en_vec;
  logic [NUM_CH-1:0] ch_rep;
  logic [NUM_CH-1:0] ev_new;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] rflag;
  logic [NUM_CH-1:0] acc_vec;
  logic [NUM_CH-1:0] pend_nxt;
  logic [NUM_CH-1:0] rflag_nxt;
  logic              lost;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_rep;

  assign rep_en_vec = (REPEAT_EN != 0) ? repeat_mask : '0;
  assign ev_new     = btn_press | ch_rep;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    btn_channel #(
      .CNT_W       (CNT_W),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_PER  (REPEAT_PER)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (btn_raw[g]),
      .rep_en(rep_en_vec[g]),
      .level (btn_level[g]),
      .press (btn_press[g]),
      .rep   (ch_rep[g])
    );
  end

  // Queue update, overrun detection and lowest-index selection
  always_comb begin
    acc_vec   = '0;
    rflag_nxt = rflag;
    sel_idx   = '0;
    sel_rep   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_vec[i] = evt_valid && evt_ready && (evt_idx == IDX_W'(i));
    end
    pend_nxt = (pending & ~acc_vec) | ev_new;
    lost     = |(ev_new & pending & ~acc_vec);
    for (int i = 0; i < NUM_CH; i++) begin
      if (btn_press[i]) begin
        rflag_nxt[i] = 1'b0;
      end else if (ch_rep[i] && !(pending[i] && !acc_vec[i])) begin
        rflag_nxt[i] = 1'b1;
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx = IDX_W'(i);
        sel_rep = rflag_nxt[i];
      end
    end
  end

  // Pending bits plus the presented event, frozen until the consumer takes it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending     <= '0;
      rflag       <= '0;
      evt_valid   <= 1'b0;
      evt_idx     <= '0;
      evt_repeat  <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      pending <= pend_nxt;
      rflag   <= rflag_nxt;
      if (lost) begin
        evt_overrun <= 1'b1;
      end
      if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end else if (!evt_valid && (|pending)) begin
        evt_valid  <= 1'b1;
        evt_idx    <= sel_idx;
        evt_repeat <= sel_rep;
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner_multi.sv
module tb_button_conditioner_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw;
  logic [3:0] repeat_mask;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic       evt_valid;
  logic [3:0] evt_idx;
  logic       evt_repeat;
  logic       evt_ready;
  logic       evt_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_conditioner_multi #(
    .NUM_CH      (4),
    .CNT_W       (8),
    .DEBOUNCE_CYC(8),
    .REPEAT_EN   (1),
    .REPEAT_DLY  (20),
    .REPEAT_PER  (5),
    .IDX_W       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .repeat_mask(repeat_mask),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_repeat (evt_repeat),
    .evt_ready  (evt_ready),
    .evt_overrun(evt_overrun)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] mask;
    logic       rdy;
    int         n;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic       vld;
    logic [3:0] idx;
    logic       rep;
    logic       ovr;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, " level"}, {28'd0, btn_level}, 32'd0);
    chk({name, " press"}, {28'd0, btn_press}, 32'd0);
    chk({name, " valid"}, {31'd0, evt_valid}, 32'd0);
    chk({name, " idx"}, {28'd0, evt_idx}, 32'd0);
    chk({name, " repeat"}, {31'd0, evt_repeat}, 32'd0);
    chk({name, " overrun"}, {31'd0, evt_overrun}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pk;
    int npress;
    int nev;
    int ev_t[8];
    logic ev_r[8];
    logic [3:0] ev_i[8];
    int exp_t[5];
    logic exp_r[5];
    int w;
    int hs;

    // raw, mask, rdy, n, lvl, prs, vld, idx, rep, ovr
    tbl[0]  = '{4'b0000, 4'b0000, 1'b0, 3,  4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0000, 1'b0, 5,  4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 1'b0, 12, 4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0100, 4'b0000, 1'b0, 9,  4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{4'b0100, 4'b0000, 1'b0, 1,  4'b0100, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 1,  4'b0100, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0100, 4'b0000, 1'b0, 1,  4'b0100, 4'b0000, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 1'b0, 5,  4'b0100, 4'b0000, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 1'b0, 6,  4'b0000, 4'b0000, 1'b1, 4'd2, 1'b0, 1'b0};
    tbl[9]  = '{4'b0000, 4'b0000, 1'b1, 1,  4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 1'b0, 3,  4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 1'b0};

    exp_t[0] = 12; exp_r[0] = 1'b0;
    exp_t[1] = 32; exp_r[1] = 1'b1;
    exp_t[2] = 37; exp_r[2] = 1'b1;
    exp_t[3] = 42; exp_r[3] = 1'b1;
    exp_t[4] = 47; exp_r[4] = 1'b1;

    reset       = 1'b0;
    btn_raw     = '0;
    repeat_mask = '0;
    evt_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    // Glitch rejection and a clean ch2 press with a stalled consumer
    for (int v = 0; v < 11; v++) begin
      btn_raw     = tbl[v].raw;
      repeat_mask = tbl[v].mask;
      evt_ready   = tbl[v].rdy;
      repeat (tbl[v].n) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d level", v), {28'd0, btn_level}, {28'd0, tbl[v].lvl});
      chk($sformatf("v%0d press", v), {28'd0, btn_press}, {28'd0, tbl[v].prs});
      chk($sformatf("v%0d valid", v), {31'd0, evt_valid}, {31'd0, tbl[v].vld});
      chk($sformatf("v%0d overrun", v), {31'd0, evt_overrun}, {31'd0, tbl[v].ovr});
      if (tbl[v].vld) begin
        chk($sformatf("v%0d idx", v), {28'd0, evt_idx}, {28'd0, tbl[v].idx});
        chk($sformatf("v%0d repeat", v), {31'd0, evt_repeat}, {31'd0, tbl[v].rep});
      end
    end

    // Auto-repeat on ch0, consumer always ready
    repeat_mask = 4'b0001;
    evt_ready   = 1'b1;
    repeat (3) @(negedge clk);
    pk = -1; npress = 0; nev = 0;
    btn_raw = 4'b0001;
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (btn_press[0]) begin
        npress++;
        pk = k;
      end
      if (evt_valid && evt_ready) begin
        if (nev < 8) begin
          ev_t[nev] = k;
          ev_r[nev] = evt_repeat;
          ev_i[nev] = evt_idx;
        end
        nev++;
      end
      if (k == 40) btn_raw = 4'b0000;
    end
    chk("rpt press count", npress, 1);
    chk("rpt press time", pk, 10);
    chk("rpt event count", nev, 5);
    for (int e = 0; e < 5; e++) begin
      if (e < nev) begin
        chk($sformatf("rpt ev%0d time", e), ev_t[e], exp_t[e]);
        chk($sformatf("rpt ev%0d flag", e), {31'd0, ev_r[e]}, {31'd0, exp_r[e]});
        chk($sformatf("rpt ev%0d idx", e), {28'd0, ev_i[e]}, 32'd0);
      end
    end
    repeat_mask = 4'b0000;
    evt_ready   = 1'b0;
    repeat (3) @(negedge clk);

    // Arbitration: ch1 and ch3 together, stall then drain
    btn_raw = 4'b1010;
    w = 0;
    while (!evt_valid && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("arb first latency", w, 12);
    chk("arb first idx", {28'd0, evt_idx}, 32'd1);
    chk("arb first repeat", {31'd0, evt_repeat}, 32'd0);
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      chk($sformatf("arb stall%0d valid", s), {31'd0, evt_valid}, 32'd1);
      chk($sformatf("arb stall%0d idx", s), {28'd0, evt_idx}, 32'd1);
    end
    evt_ready = 1'b1;
    @(negedge clk);
    chk("arb gap valid", {31'd0, evt_valid}, 32'd0);
    @(negedge clk);
    chk("arb second valid", {31'd0, evt_valid}, 32'd1);
    chk("arb second idx", {28'd0, evt_idx}, 32'd3);
    chk("arb second repeat", {31'd0, evt_repeat}, 32'd0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      chk($sformatf("arb drained%0d valid", s), {31'd0, evt_valid}, 32'd0);
    end
    evt_ready = 1'b0;
    btn_raw   = 4'b0000;
    repeat (14) @(negedge clk);
    chk("arb release level", {28'd0, btn_level}, 32'd0);
    chk("arb release valid", {31'd0, evt_valid}, 32'd0);

    // Overrun: two ch0 presses while stalled
    btn_raw = 4'b0001;
    repeat (12) @(negedge clk);
    btn_raw = 4'b0000;
    repeat (12) @(negedge clk);
    chk("ovr first valid", {31'd0, evt_valid}, 32'd1);
    chk("ovr first overrun", {31'd0, evt_overrun}, 32'd0);
    btn_raw = 4'b0001;
    repeat (12) @(negedge clk);
    btn_raw = 4'b0000;
    repeat (14) @(negedge clk);
    chk("ovr flag", {31'd0, evt_overrun}, 32'd1);
    chk("ovr valid", {31'd0, evt_valid}, 32'd1);
    chk("ovr idx", {28'd0, evt_idx}, 32'd0);
    evt_ready = 1'b1;
    hs = 0;
    for (int s = 0; s < 8; s++) begin
      if (evt_valid && evt_ready) hs++;
      @(negedge clk);
    end
    chk("ovr delivered count", hs, 1);
    chk("ovr sticky", {31'd0, evt_overrun}, 32'd1);
    evt_ready = 1'b0;

    // Reset in HOLD_REP with events pending, button kept held
    repeat_mask = 4'b0001;
    btn_raw     = 4'b0001;
    repeat (33) @(negedge clk);
    chk("rst pre valid", {31'd0, evt_valid}, 32'd1);
    chk("rst pre level", {28'd0, btn_level}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("rst async");
    repeat (2) @(negedge clk);
    chk_zero("rst held");
    reset = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 9) chk("rst relevel early", {28'd0, btn_level}, 32'd0);
      if (k == 10) begin
        chk("rst relevel", {28'd0, btn_level}, 32'd1);
        chk("rst repress", {28'd0, btn_press}, 32'd1);
      end
      if (k == 11) chk("rst gap valid", {31'd0, evt_valid}, 32'd0);
      if (k == 12) begin
        chk("rst event valid", {31'd0, evt_valid}, 32'd1);
        chk("rst event idx", {28'd0, evt_idx}, 32'd0);
        chk("rst event repeat", {31'd0, evt_repeat}, 32'd0);
        chk("rst overrun cleared", {31'd0, evt_overrun}, 32'd0);
      end
    end

    btn_raw     = 4'b0000;
    repeat_mask = 4'b0000;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
